// File: rtl/lab0_pkg.sv
// Shared types and default truth tables for the lab0 response checker.
package lab0_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int N_IN_DEF = 3;
    localparam int N_VEC    = 2 ** N_IN_DEF;

    // Majority and odd parity over {a,b,c}, indexed by vector value.
    localparam logic [N_VEC-1:0] EXP_Y_DEF = 8'hE8;
    localparam logic [N_VEC-1:0] EXP_Z_DEF = 8'h96;

endpackage

// File: rtl/lab0_response_checker.sv
// Drives every input vector onto the lab0 DUT in order, checks y/z against truth tables
// and reports mismatch count, first failing vector and pass/done status.
module lab0_response_checker
    import lab0_pkg::*;
#(
    parameter int                   N_IN        = N_IN_DEF,
    parameter int                   HOLD_CYCLES = 1,
    parameter logic [2**N_IN-1:0]   EXP_Y       = EXP_Y_DEF,
    parameter logic [2**N_IN-1:0]   EXP_Z       = EXP_Z_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            a,
    output logic            b,
    output logic            c,
    input  logic            y,
    input  logic            z,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_fail_vec,
    output logic            first_fail_valid
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    state_t          state;
    logic [N_IN-1:0] vec;
    logic [HW-1:0]   hold;
    logic            sample;
    logic            mismatch;

    assign sample   = (hold == HW'(HOLD_CYCLES - 1));
    assign mismatch = (y != EXP_Y[vec]) || (z != EXP_Z[vec]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            vec              <= '0;
            hold             <= '0;
            {a, b, c}        <= 3'b000;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state            <= RUN;
                        vec              <= '0;
                        hold             <= '0;
                        {a, b, c}        <= 3'b000;
                        busy             <= 1'b1;
                        done             <= 1'b0;
                        pass             <= 1'b0;
                        err_count        <= '0;
                        first_fail_vec   <= '0;
                        first_fail_valid <= 1'b0;
                    end
                end
                RUN: begin
                    if (sample) begin
                        if (mismatch) begin
                            err_count <= err_count + 1'b1;
                            if (!first_fail_valid) begin
                                first_fail_vec   <= vec;
                                first_fail_valid <= 1'b1;
                            end
                        end
                        if (vec == N_IN'(2 ** N_IN - 1)) begin
                            // Last vector: {a,b,c} stays at all-ones while results are held.
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_count == '0) && !mismatch;
                        end else begin
                            vec       <= vec + 1'b1;
                            hold      <= '0;
                            {a, b, c} <= 3'(vec + 1'b1);
                        end
                    end else begin
                        hold <= hold + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lab0_response_checker.sv
// Bench for lab0_response_checker: behavioural lab0 DUT with injectable faults, two checker instances.
module tb_lab0_response_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start1, start2;
    logic a1, b1, c1, y1, z1, busy1, done1, pass1, vld1;
    logic a2, b2, c2, y2, z2, busy2, done2, pass2, vld2;
    logic [3:0] err1, err2;
    logic [2:0] ffv1, ffv2;

    logic [7:0] ymask, zmask;
    logic       zstuck;

    // Behavioural DUT: majority / odd parity with per-vector flips and a stuck-at-0 on z.
    always_comb begin
        y1 = ((a1 & b1) | (a1 & c1) | (b1 & c1)) ^ ymask[{a1, b1, c1}];
        z1 = zstuck ? 1'b0 : ((a1 ^ b1 ^ c1) ^ zmask[{a1, b1, c1}]);
        y2 = ((a2 & b2) | (a2 & c2) | (b2 & c2)) ^ ymask[{a2, b2, c2}];
        z2 = zstuck ? 1'b0 : ((a2 ^ b2 ^ c2) ^ zmask[{a2, b2, c2}]);
    end

    lab0_response_checker #(.HOLD_CYCLES(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .a(a1), .b(b1), .c(c1), .y(y1), .z(z1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_fail_vec(ffv1), .first_fail_valid(vld1)
    );

    lab0_response_checker #(.HOLD_CYCLES(2)) u_dut2 (
        .clk(clk), .reset(reset), .start(start2), .a(a2), .b(b2), .c(c2), .y(y2), .z(z2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .first_fail_vec(ffv2), .first_fail_valid(vld2)
    );

    int         sel;
    logic [2:0] s_abc, s_ffv;
    logic [3:0] s_err;
    logic       s_busy, s_done, s_pass, s_vld;

    always_comb begin
        if (sel == 2) begin
            s_abc = {a2, b2, c2}; s_ffv = ffv2; s_err = err2;
            s_busy = busy2; s_done = done2; s_pass = pass2; s_vld = vld2;
        end else begin
            s_abc = {a1, b1, c1}; s_ffv = ffv1; s_err = err1;
            s_busy = busy1; s_done = done1; s_pass = pass1; s_vld = vld1;
        end
    end

    typedef struct {
        int         hold;
        logic [7:0] ym;
        logic [7:0] zm;
        logic       zs;
        int         exp_err;
        int         exp_ffv;
        int         exp_vld;
        int         exp_pass;
        int         extra_start;
    } row_t;

    row_t tbl[8];
    int   checks = 0;
    int   errors = 0;
    int   exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic pulse_start();
        if (sel == 2) start2 = 1'b1;
        else start1 = 1'b1;
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_abc"}, s_abc, 0);
        chk({tag, "_busy"}, s_busy, 0);
        chk({tag, "_done"}, s_done, 0);
        chk({tag, "_pass"}, s_pass, 0);
        chk({tag, "_err"}, s_err, 0);
        chk({tag, "_ffv"}, s_ffv, 0);
        chk({tag, "_vld"}, s_vld, 0);
    endtask

    task automatic run_row(input row_t r);
        int h;
        h      = r.hold;
        sel    = (h == 2) ? 2 : 1;
        ymask  = r.ym;
        zmask  = r.zm;
        zstuck = r.zs;
        @(negedge clk);
        pulse_start();
        @(posedge clk); #1;
        start1 = 1'b0; start2 = 1'b0;
        for (int j = 0; j < 8 * h; j++) exp_q.push_back(j / h);
        chk("restart_err_clear", s_err, 0);
        chk("restart_vld_clear", s_vld, 0);
        for (int j = 0; j < 8 * h; j++) begin
            chk("abc_seq", s_abc, exp_q.pop_front());
            chk("busy_run", s_busy, 1);
            chk("done_run", s_done, 0);
            if (j == r.extra_start) pulse_start();
            @(posedge clk); #1;
            start1 = 1'b0; start2 = 1'b0;
        end
        chk("done_at_end", s_done, 1);
        chk("busy_at_end", s_busy, 0);
        chk("err_count", s_err, r.exp_err);
        chk("first_fail_vec", s_ffv, r.exp_ffv);
        chk("first_fail_valid", s_vld, r.exp_vld);
        chk("pass", s_pass, r.exp_pass);
        chk("abc_final", s_abc, 7);
        @(posedge clk); #1;
        chk("done_held", s_done, 1);
        chk("err_held", s_err, r.exp_err);
        chk("abc_held", s_abc, 7);
    endtask

    initial begin
        //          hold ymask   zmask   zs    err ffv vld pass extra
        tbl[0] = '{1, 8'h00, 8'h00, 1'b0, 0, 0, 0, 1, -1};  // correct DUT
        tbl[1] = '{1, 8'h00, 8'h00, 1'b1, 4, 1, 1, 0, -1};  // z stuck at 0
        tbl[2] = '{1, 8'h00, 8'h00, 1'b0, 0, 0, 0, 1, -1};  // restart from DONE
        tbl[3] = '{2, 8'h40, 8'h00, 1'b0, 1, 6, 1, 0, -1};  // y wrong at 6, hold 2
        tbl[4] = '{1, 8'h20, 8'h20, 1'b0, 1, 5, 1, 0, -1};  // y and z wrong at 5
        tbl[5] = '{2, 8'h00, 8'h81, 1'b0, 2, 0, 1, 0, -1};  // z wrong at 0 and 7
        tbl[6] = '{1, 8'hFF, 8'h00, 1'b0, 8, 0, 1, 0, -1};  // every vector fails
        tbl[7] = '{1, 8'h00, 8'h00, 1'b0, 0, 0, 0, 1, 3};   // start mid-run ignored

        sel = 1; ymask = '0; zmask = '0; zstuck = 1'b0;
        start1 = 1'b0; start2 = 1'b0; reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        sel = 1; check_idle_zero("reset1");
        sel = 2; check_idle_zero("reset2");
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        sel = 1; chk("idle_no_start", s_busy, 0);

        for (int i = 0; i < 8; i++) run_row(tbl[i]);

        // Reset in the middle of a failing run discards everything.
        sel = 1; ymask = 8'hFF; zmask = '0; zstuck = 1'b0;
        @(negedge clk); start1 = 1'b1;
        @(posedge clk); #1; start1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midrun_abc", s_abc, 3);
        chk("midrun_err", s_err, 3);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        check_idle_zero("midrun_reset");
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_idle", s_busy, 0);
        chk("post_reset_abc", s_abc, 0);

        run_row(tbl[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
